bram_rd_arbiter: RTL and testbench
==================================

// Module: bram_rd_arbiter
// PURPOSE
//  Shares one bram read port among NUM_REQ requesters with round-robin arbitration.
//  Zero-fills the bram after reset or on a clear pulse, then forwards one write port.
//  Sits between client datapaths and a bram instance; owns bram rd_en/rd_addr/wr_*.
// PARAMETERS
//  BRAM_DWIDTH  32  bram data width
//  BRAM_AWIDTH  8   bram address width; DEPTH = 1<<BRAM_AWIDTH
//  NUM_REQ      2   number of read requesters, 2..8
// PORTS
//  clk          in   1                   single clock, rising edge
//  rst_n        in   1                   asynchronous, active-low reset
//  clear        in   1                   pulse: restart zero-fill
//  init_done    out  1                   1 once zero-fill complete (RUN state)
//  req_valid    in   NUM_REQ             per-requester read request
//  req_ready    out  NUM_REQ             per-requester grant (one-hot or zero)
//  req_addr     in   NUM_REQ*AWIDTH      packed read addresses, requester i at [i*AW+:AW]
//  rsp_valid    out  NUM_REQ             one-hot pulse: rsp_data belongs to requester i
//  rsp_data     out  BRAM_DWIDTH         read data (bram rd_data passed through)
//  wr_valid     in   1                   client write request
//  wr_ready     out  1                   write accepted this cycle
//  wr_addr      in   BRAM_AWIDTH         client write address
//  wr_data      in   BRAM_DWIDTH         client write data
//  bram_rd_en   out  1                   to bram rd_en
//  bram_rd_addr out  BRAM_AWIDTH         to bram rd_addr
//  bram_rd_data in   BRAM_DWIDTH         from bram rd_data (1-cycle latency, 0 when not rd_en)
//  bram_wr_en   out  1                   to bram wr_en
//  bram_wr_addr out  BRAM_AWIDTH         to bram wr_addr
//  bram_wr_data out  BRAM_DWIDTH         to bram wr_data
// BEHAVIOUR
//  States INIT, RUN. Reset -> INIT, fill addr=0, rr pointer=0, rsp_valid=0, init_done=0.
//  INIT: each cycle bram_wr_en=1, addr=fill, data=0; fill++. At fill==DEPTH-1 -> RUN next.
//   INIT takes exactly DEPTH cycles. req_ready=0, wr_ready=0, bram_rd_en=0 during INIT.
//  RUN: init_done=1. clear=1 in any state -> INIT with fill=0 next cycle (clear in INIT restarts).
//  Read arbitration (RUN only): grant = first valid requester at or after rr pointer, wrapping.
//   req_ready[g]=1 combinationally; bram_rd_en=1, bram_rd_addr=req_addr[g] same cycle.
//   After a grant the pointer moves to g+1 (mod NUM_REQ); no grant -> pointer unchanged.
//   Handshake: transfer on req_valid&req_ready; requesters hold valid/addr until ready.
//  Response: rsp_valid registered copy of req_ready, so it pulses exactly 1 cycle after accept;
//   rsp_data = bram_rd_data. No backpressure on responses. Throughput 1 read/cycle total.
//  Write: RUN only; wr_ready = 1 whenever state==RUN and clear==0; bram_wr_* = wr_* when
//   wr_valid&wr_ready, else bram_wr_en=0. Writes never stall reads (separate bram ports).
//  Same-cycle read and write to one address: read returns old data (bram read-first).
//  clear in a cycle with a granted read: read completes (rsp_valid next cycle), then INIT.
//  rst_n low mid-operation: all outputs zero asynchronously, in-flight rsp_valid dropped.
// CONFIGURATION
//  BRAM_ARB_STATS_EN defined: adds output grant_cnt [NUM_REQ*16], per-requester 16-bit
//   saturating count of accepted reads; zeroed on reset and on entry to INIT; holds at 16'hFFFF.
//  Not defined: no grant_cnt port, no counter logic.
// STRUCTURE
//  bram_arb_pkg: state_t enum {INIT, RUN}, localparam CNT_W=16, function for rr search.
//  Sub-module rr_arbiter (NUM_REQ): req vector in, one-hot grant out, holds pointer register.
//  bram_rd_arbiter: INIT/RUN fsm, fill counter, addr mux, rsp pipeline, optional counters.
// TESTING
//  Reset, AW=4: 16 INIT cycles with bram_wr_en=1, addr 0..15, data 0; init_done at cycle 16.
//  Write 0xA5 to addr 3, then req0 reads addr 3 -> rsp_valid=01 one cycle later, rsp_data=0xA5.
//  req0,req1 held valid continuously -> grants alternate 01,10,01,10; rsp_valid follows by 1.
//  Read and write addr 5 same cycle (old 0, new 0x77) -> rsp_data=0; next read returns 0x77.
//  clear pulse mid-RUN during a grant -> that rsp arrives, init_done drops, 16-cycle refill, reads 0.
//  STATS_EN: 3 reads by req1 -> grant_cnt[1]=3; clear -> grant_cnt all 0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and the round-robin search used by the bram read arbiter.
package bram_arb_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int CNT_W   = 16;
   localparam int MAX_REQ = 8;

   // Returns a one-hot grant for the first set bit of req at or after ptr, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_search(
      input logic [MAX_REQ-1:0] req,
      input int unsigned        ptr,
      input int unsigned        n
   );
      logic [MAX_REQ-1:0] grant;
      int unsigned        idx;
      grant = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if (k < n && grant == '0 && req[idx[2:0]]) grant[idx[2:0]] = 1'b1;
      end
      return grant;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer advances past the last winner.
module rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   ptr_nxt;
   logic [MAX_REQ-1:0] req_ext;
   logic [MAX_REQ-1:0] grant_ext;

   always_comb begin
      req_ext                = '0;
      req_ext[NUM_REQ-1:0]   = req;
      grant_ext              = en ? rr_search(req_ext, 32'(ptr), NUM_REQ) : '0;
      ptr_nxt                = ptr;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (grant_ext[k]) ptr_nxt = (k + 1 >= NUM_REQ) ? '0 : PTR_W'(k + 1);
      end
      grant = grant_ext[NUM_REQ-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_nxt;
   end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Shares one bram read port among NUM_REQ requesters, zero-fills the bram, forwards writes.
// Optional BRAM_ARB_STATS_EN adds per-requester saturating grant counters (grant_cnt).
module bram_rd_arbiter
   import bram_arb_pkg::*;
#(
   parameter int BRAM_DWIDTH = 32,
   parameter int BRAM_AWIDTH = 8,
   parameter int NUM_REQ     = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   output logic                           init_done,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*BRAM_AWIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [BRAM_DWIDTH-1:0]         rsp_data,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [BRAM_AWIDTH-1:0]         wr_addr,
   input  logic [BRAM_DWIDTH-1:0]         wr_data,
   output logic                           bram_rd_en,
   output logic [BRAM_AWIDTH-1:0]         bram_rd_addr,
   input  logic [BRAM_DWIDTH-1:0]         bram_rd_data,
   output logic                           bram_wr_en,
   output logic [BRAM_AWIDTH-1:0]         bram_wr_addr,
   output logic [BRAM_DWIDTH-1:0]         bram_wr_data
`ifdef BRAM_ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0]       grant_cnt
`endif
);

   state_t                 state;
   logic [BRAM_AWIDTH-1:0] fill;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state == RUN),
      .req   (req_valid),
      .grant (req_ready)
   );

   // A clear restarts the fill from any state; a read granted in the same cycle still completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         fill      <= '0;
         init_done <= 1'b0;
         rsp_valid <= '0;
      end else begin
         rsp_valid <= req_ready;
         if (clear) begin
            state     <= INIT;
            fill      <= '0;
            init_done <= 1'b0;
         end else begin
            case (state)
               INIT: begin
                  fill <= fill + 1'b1;
                  if (&fill) begin
                     state     <= RUN;
                     init_done <= 1'b1;
                  end
               end
               RUN:     ;
               default: state <= INIT;
            endcase
         end
      end
   end

   always_comb begin
      bram_rd_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) bram_rd_addr = bram_rd_addr | req_addr[i*BRAM_AWIDTH +: BRAM_AWIDTH];
      end
   end

   assign bram_rd_en = |req_ready;
   assign rsp_data   = bram_rd_data;

   // The fill write is gated by rst_n so the bram sees no write while reset is held.
   always_comb begin
      wr_ready     = (state == RUN) && !clear;
      bram_wr_en   = 1'b0;
      bram_wr_addr = '0;
      bram_wr_data = '0;
      if (state == INIT) begin
         bram_wr_en   = rst_n;
         bram_wr_addr = fill;
      end else if (wr_valid && wr_ready) begin
         bram_wr_en   = 1'b1;
         bram_wr_addr = wr_addr;
         bram_wr_data = wr_data;
      end
   end

`ifdef BRAM_ARB_STATS_EN
   logic [CNT_W-1:0] cnt [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
   end
`endif

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Scoreboard bench for bram_rd_arbiter with a read-first bram model; AW=4, two requesters.
module tb_bram_rd_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int NR    = 2;
   localparam int DEPTH = 16;

   logic              clk;
   logic              rst_n;
   logic              clear;
   logic              init_done;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*AW-1:0]  req_addr;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic              bram_rd_en;
   logic [AW-1:0]     bram_rd_addr;
   logic [DW-1:0]     bram_rd_data;
   logic              bram_wr_en;
   logic [AW-1:0]     bram_wr_addr;
   logic [DW-1:0]     bram_wr_data;
`ifdef BRAM_ARB_STATS_EN
   logic [NR*16-1:0]  grant_cnt;
`endif

   typedef struct {
      logic [NR-1:0] who;
      logic [DW-1:0] data;
   } exp_t;

   exp_t expq[$];
   int   checks   = 0;
   int   failures = 0;

   logic [DW-1:0] mem [DEPTH];

   bram_rd_arbiter #(.BRAM_DWIDTH(DW), .BRAM_AWIDTH(AW), .NUM_REQ(NR)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .init_done    (init_done),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .bram_rd_en   (bram_rd_en),
      .bram_rd_addr (bram_rd_addr),
      .bram_rd_data (bram_rd_data),
      .bram_wr_en   (bram_wr_en),
      .bram_wr_addr (bram_wr_addr),
      .bram_wr_data (bram_wr_data)
`ifdef BRAM_ARB_STATS_EN
      ,
      .grant_cnt    (grant_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read-first bram with one cycle of read latency, preloaded with garbage so the fill is visible.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_0000 | i;
   end

   always @(posedge clk) begin
      bram_rd_data <= bram_rd_en ? mem[bram_rd_addr] : '0;
      if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NR-1:0] rv, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic clr);
      @(negedge clk);
      req_valid = rv;
      req_addr  = {a1, a0};
      wr_valid  = wv;
      wr_addr   = wa;
      wr_data   = wd;
      clear     = clr;
      #1;
   endtask

   task automatic doRead(input string tag, input logic [NR-1:0] rv, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [NR-1:0] exp_grant, input logic [DW-1:0] exp_data);
      exp_t e;
      applyStimulus(rv, a0, a1, 1'b0, '0, '0, 1'b0);
      checkOutput({tag, "_ready"}, 64'(req_ready), 64'(exp_grant));
      checkOutput({tag, "_rd_addr"}, 64'(bram_rd_addr), 64'(exp_grant[1] ? a1 : a0));
      e.who  = exp_grant;
      e.data = exp_data;
      expq.push_back(e);
   endtask

   // Checks the 16 zero-fill cycles while a request is held that must not be granted.
   task automatic initFill(input string tag);
      for (int k = 0; k < DEPTH; k++) begin
         applyStimulus(2'b01, '0, '0, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
         checkOutput({tag, "_wr_en"}, 64'(bram_wr_en), 64'(1));
         checkOutput({tag, "_wr_addr"}, 64'(bram_wr_addr), 64'(k));
         checkOutput({tag, "_wr_data"}, 64'(bram_wr_data), 64'(0));
         checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'(0));
         checkOutput({tag, "_rd_en"}, 64'(bram_rd_en), 64'(0));
         checkOutput({tag, "_wr_ready"}, 64'(wr_ready), 64'(0));
         checkOutput({tag, "_init_done"}, 64'(init_done), 64'(0));
      end
      applyStimulus('0, '0, '0, 1'b0, '0, '0, 1'b0);
      checkOutput({tag, "_done"}, 64'(init_done), 64'(1));
      checkOutput({tag, "_done_wr_en"}, 64'(bram_wr_en), 64'(0));
   endtask

   // Scoreboard monitor: every response pulse must match the oldest expected read.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid != '0) begin
         if (expq.size() == 0) begin
            checkOutput("rsp_unexpected", 64'(rsp_valid), 64'(0));
         end else begin
            exp_t e;
            e = expq.pop_front();
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(e.who));
            checkOutput("rsp_data", 64'(rsp_data), 64'(e.data));
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      exp_t e;
      rst_n     = 1'b0;
      clear     = 1'b0;
      req_valid = 2'b01;
      req_addr  = '0;
      wr_valid  = 1'b1;
      wr_addr   = '0;
      wr_data   = '0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_wr_en", 64'(bram_wr_en), 64'(0));
      checkOutput("rst_init_done", 64'(init_done), 64'(0));
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
      checkOutput("rst_rd_en", 64'(bram_rd_en), 64'(0));
      checkOutput("rst_wr_ready", 64'(wr_ready), 64'(0));

      @(posedge clk);
      #2 rst_n = 1'b1;
      initFill("init");
      checkOutput("run_wr_ready", 64'(wr_ready), 64'(1));

      applyStimulus('0, '0, '0, 1'b1, 4'd3, 32'hA5, 1'b0);
      checkOutput("wr_ready", 64'(wr_ready), 64'(1));
      checkOutput("wr_en", 64'(bram_wr_en), 64'(1));
      checkOutput("wr_addr", 64'(bram_wr_addr), 64'(3));
      checkOutput("wr_data", 64'(bram_wr_data), 64'(32'hA5));

      doRead("rd_a5", 2'b01, 4'd3, 4'd0, 2'b01, 32'hA5);
      checkOutput("rd_a5_rd_en", 64'(bram_rd_en), 64'(1));
      doRead("rd_r1", 2'b10, 4'd0, 4'd4, 2'b10, 32'h0);

      for (int i = 0; i < 4; i++) begin
         doRead("alt", 2'b11, 4'd3, 4'd4, (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 32'hA5 : 32'h0);
      end

      applyStimulus('0, '0, '0, 1'b0, '0, '0, 1'b0);
      checkOutput("idle_ready", 64'(req_ready), 64'(0));
      checkOutput("idle_rd_en", 64'(bram_rd_en), 64'(0));

      applyStimulus(2'b01, 4'd5, 4'd0, 1'b1, 4'd5, 32'h77, 1'b0);
      checkOutput("rw_ready", 64'(req_ready), 64'(2'b01));
      checkOutput("rw_wr_en", 64'(bram_wr_en), 64'(1));
      e.who = 2'b01; e.data = 32'h0;
      expq.push_back(e);
      doRead("rd_new", 2'b01, 4'd5, 4'd0, 2'b01, 32'h77);

      applyStimulus(2'b10, 4'd0, 4'd5, 1'b1, 4'd7, 32'h1234, 1'b1);
      checkOutput("clr_ready", 64'(req_ready), 64'(2'b10));
      checkOutput("clr_wr_ready", 64'(wr_ready), 64'(0));
      checkOutput("clr_wr_en", 64'(bram_wr_en), 64'(0));
      e.who = 2'b10; e.data = 32'h77;
      expq.push_back(e);
      initFill("refill");

      doRead("rd_z5", 2'b01, 4'd5, 4'd0, 2'b01, 32'h0);
      doRead("rd_z3", 2'b01, 4'd3, 4'd0, 2'b01, 32'h0);
      for (int i = 0; i < 3; i++) doRead("rd_r1x", 2'b10, 4'd0, 4'd7, 2'b10, 32'h0);
      applyStimulus('0, '0, '0, 1'b0, '0, '0, 1'b0);
`ifdef BRAM_ARB_STATS_EN
      checkOutput("grant_cnt", 64'(grant_cnt), 64'({16'd3, 16'd2}));
`endif
      applyStimulus('0, '0, '0, 1'b0, '0, '0, 1'b1);
      initFill("refill2");
`ifdef BRAM_ARB_STATS_EN
      checkOutput("grant_cnt_clr", 64'(grant_cnt), 64'(0));
`endif

      applyStimulus(2'b01, 4'd3, 4'd0, 1'b0, '0, '0, 1'b0);
      checkOutput("inflight_ready", 64'(req_ready), 64'(2'b01));
      @(posedge clk);
      #1;
      checkOutput("inflight_rsp", 64'(rsp_valid), 64'(2'b01));
      #1 rst_n = 1'b0;
      #1;
      checkOutput("arst_rsp", 64'(rsp_valid), 64'(0));
      checkOutput("arst_ready", 64'(req_ready), 64'(0));
      checkOutput("arst_rd_en", 64'(bram_rd_en), 64'(0));
      checkOutput("arst_wr_en", 64'(bram_wr_en), 64'(0));
      checkOutput("arst_done", 64'(init_done), 64'(0));

      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) applyStimulus('0, '0, '0, 1'b0, '0, '0, 1'b0);
      applyStimulus('0, '0, '0, 1'b0, '0, '0, 1'b1);
      checkOutput("mid_init_fill", 64'(bram_wr_addr), 64'(5));
      initFill("restart");

      repeat (2) @(negedge clk);
      checkOutput("queue_empty", 64'(expq.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
